hs_ring_fifo: RTL and testbench

//  Clocked successor to the 4-phase handshake ring: a DEPTH-entry, WIDTH-bit token/data ring buffer

---
 rtl/hs_ring_pkg.sv | 20 ++
 rtl/hs_sync.sv | 20 ++
 rtl/hs_ring_fifo.sv | 130 +++++++++++++
 tb/tb_hs_ring_fifo.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_ring_pkg.sv
// Shared types and helpers for the handshake ring FIFO.
package hs_ring_pkg;

  typedef enum logic {
    L_IDLE,
    L_ACK
  } l_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SETUP,
    R_ACK,
    R_REL
  } r_state_t;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchroniser with asynchronous active-low clear.
module hs_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/hs_ring_fifo.sv
// Ring buffer bridging a 4-phase bundled-data sender and receiver, with an
// la period monitor.
module hs_ring_fifo
  import hs_ring_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lr,
  input  logic [WIDTH-1:0]           ld,
  output logic                       la,
  output logic                       rr,
  output logic [WIDTH-1:0]           rd,
  input  logic                       ra,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           cycle_time,
  output logic                       cycle_valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  l_state_t         l_state;
  r_state_t         r_state;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             lr_s;
  logic             ra_s;
  logic             cap;
  logic             rcommit;
  logic [CNT_W-1:0] mon_cnt;
  logic             seen_rise;

  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_lr (.clk(clk), .rst_n(rst_n), .d(lr), .q(lr_s));
  hs_sync #(.STAGES(SYNC_STAGES)) u_sync_ra (.clk(clk), .rst_n(rst_n), .d(ra), .q(ra_s));

  // An entry is counted at capture, so a full ring blocks the next capture at once.
  assign cap     = (l_state == L_IDLE) && lr_s && (count < FULL);
  assign rcommit = (r_state == R_ACK) && ra_s;

  always_ff @(posedge clk) begin
    if (cap) mem[wptr] <= ld;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state <= L_IDLE;
      la      <= 1'b0;
      wptr    <= '0;
    end else begin
      case (l_state)
        L_IDLE: if (cap) begin
          la      <= 1'b1;
          l_state <= L_ACK;
        end
        L_ACK: if (!lr_s) begin
          la      <= 1'b0;
          wptr    <= PW'(ptr_inc(32'(wptr), DEPTH));
          l_state <= L_IDLE;
        end
        default: l_state <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rr      <= 1'b0;
      rd      <= '0;
      rptr    <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (count != '0) begin
          rd      <= mem[rptr];
          r_state <= R_SETUP;
        end
        R_SETUP: begin
          rr      <= 1'b1;
          r_state <= R_ACK;
        end
        R_ACK: if (ra_s) begin
          rr      <= 1'b0;
          rptr    <= PW'(ptr_inc(32'(rptr), DEPTH));
          r_state <= R_REL;
        end
        R_REL: if (!ra_s) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({cap, rcommit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // cap is exactly the edge on which la goes 0->1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_cnt     <= '0;
      seen_rise   <= 1'b0;
      cycle_time  <= '0;
      cycle_valid <= 1'b0;
    end else if (cap) begin
      mon_cnt   <= CNT_W'(1);
      seen_rise <= 1'b1;
      if (seen_rise) begin
        cycle_time  <= mon_cnt;
        cycle_valid <= 1'b1;
      end
    end else if (mon_cnt != '1) begin
      mon_cnt <= mon_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hs_ring_fifo.sv
// Scoreboard bench for hs_ring_fifo: directed tokens in, monitor checks order out.
module tb_hs_ring_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lr = 1'b0;
  logic [WIDTH-1:0] ld = '0;
  logic             ra = 1'b0;
  logic             la;
  logic             rr;
  logic [WIDTH-1:0] rd;
  logic [2:0]       count;
  logic [CNT_W-1:0] cycle_time;
  logic             cycle_valid;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];
  int ra_mode = 0;  // 0: hold low, 1: echo rr, 2: hold high

  hs_ring_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .SYNC_STAGES(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lr(lr),
    .ld(ld),
    .la(la),
    .rr(rr),
    .rd(rd),
    .ra(ra),
    .count(count),
    .cycle_time(cycle_time),
    .cycle_valid(cycle_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_la(input logic v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (la === v) begin
        ok = 1'b1;
        return;
      end
      tick(1);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    bit ok;
    ld = d;
    lr = 1'b1;
    exp_q.push_back(d);
    wait_la(1'b1, 60, ok);
    chk("push_ack", 32'(ok), 1);
    lr = 1'b0;
    wait_la(1'b0, 60, ok);
    chk("push_release", 32'(ok), 1);
  endtask

  task automatic wait_drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && count == 0 && !rr) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    chk("drain", 32'(ok), 1);
  endtask

  // Right-side responder; acts 2 time units after the edge so a mode change
  // made at +1 lands before the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ra_mode)
        1:       ra = rr;
        2:       ra = 1'b1;
        default: ra = 1'b0;
      endcase
    end
  end

  // Output monitor: every rr rising edge presents one token.
  initial begin : monitor
    logic rr_q;
    logic [WIDTH-1:0] e;
    rr_q = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rr && !rr_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_token", 32'(rd), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rd_order", 32'(rd), 32'(e));
        end
      end
      rr_q = rr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    int rises;
    int last_edge;
    int cyc;
    int per[$];
    logic la_q;
    logic [WIDTH-1:0] tok;

    // Reset state
    tick(2);
    chk("rst_la", 32'(la), 0);
    chk("rst_rr", 32'(rr), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_cycle_time", 32'(cycle_time), 0);
    chk("rst_cycle_valid", 32'(cycle_valid), 0);
    rst_n = 1'b1;
    tick(2);

    // 1: reset mid-handshake aborts it (token never expected at the output)
    ld = 8'h3C;
    lr = 1'b1;
    wait_la(1'b1, 20, ok);
    chk("t1_la_up", 32'(ok), 1);
    chk("t1_count_up", 32'(count), 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_la", 32'(la), 0);
    chk("t1_rst_rr", 32'(rr), 0);
    chk("t1_rst_count", 32'(count), 0);
    chk("t1_rst_valid", 32'(cycle_valid), 0);
    lr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("t1_empty_count", 32'(count), 0);
    chk("t1_empty_rr", 32'(rr), 0);

    // 2: single token, lr->la latency of 3 clocks
    ra_mode = 1;
    ld = 8'hA5;
    lr = 1'b1;
    exp_q.push_back(8'hA5);
    n = 0;
    while (!la && n < 20) begin
      tick(1);
      n++;
    end
    chk("t2_la_latency", 32'(n), 3);
    lr = 1'b0;
    wait_la(1'b0, 20, ok);
    chk("t2_la_down", 32'(ok), 1);
    wait_drain(100);
    chk("t2_count_zero", 32'(count), 0);

    // 3: fill to DEPTH with ra held low, 5th token stalls
    ra_mode = 0;
    tick(4);
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("t3_full_count", 32'(count), 4);
    ld = 8'h05;
    lr = 1'b1;
    exp_q.push_back(8'h05);
    tick(8);
    chk("t3_stall_la", 32'(la), 0);
    chk("t3_stall_count", 32'(count), 4);
    ra_mode = 1;
    wait_la(1'b1, 100, ok);
    chk("t3_fifth_ack", 32'(ok), 1);
    lr = 1'b0;
    wait_la(1'b0, 20, ok);
    chk("t3_fifth_rel", 32'(ok), 1);
    wait_drain(300);

    // 5: capture and read commit on the same edge leave count unchanged
    ra_mode = 0;
    tick(4);
    push(8'h11);
    push(8'h22);
    n = 0;
    while (!rr && n < 30) begin
      tick(1);
      n++;
    end
    chk("t5_rr_wait", 32'(rr), 1);
    chk("t5_count_before", 32'(count), 2);
    ld = 8'h33;
    exp_q.push_back(8'h33);
    lr = 1'b1;
    ra_mode = 2;
    tick(5);
    chk("t5_la", 32'(la), 1);
    chk("t5_rr", 32'(rr), 0);
    chk("t5_count_after", 32'(count), 2);
    lr = 1'b0;
    wait_la(1'b0, 20, ok);
    chk("t5_la_down", 32'(ok), 1);
    ra_mode = 1;
    wait_drain(300);

    // 4: ten tokens across pointer wrap
    for (int i = 0; i < 10; i++) push(8'(i));
    wait_drain(300);

    // 6: period monitor with lr=~la, ra=rr
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("t6_valid_reset", 32'(cycle_valid), 0);
    rises = 0;
    last_edge = 0;
    cyc = 0;
    la_q = 1'b0;
    tok = 8'h40;
    while (rises < 40 && cyc < 3000) begin
      if (la && !la_q) begin
        rises++;
        if (rises == 1) begin
          chk("t6_valid_first", 32'(cycle_valid), 0);
        end else begin
          per.push_back(cyc - last_edge);
          chk("t6_valid", 32'(cycle_valid), 1);
          chk("t6_cycle_time", 32'(cycle_time), 32'(cyc - last_edge));
        end
        last_edge = cyc;
      end
      la_q = la;
      if (la) begin
        lr = 1'b0;
      end else if (!lr) begin
        ld = tok;
        exp_q.push_back(tok);
        tok = tok + 1'b1;
        lr = 1'b1;
      end
      if (rises == 40) break;
      tick(1);
      cyc++;
    end
    chk("t6_rises", 32'(rises), 40);
    for (int i = per.size() - 5; i < per.size() - 1; i++)
      chk("t6_period_const", 32'(per[i]), 32'(per[per.size()-1]));
    wait_la(1'b0, 20, ok);
    chk("t6_la_down", 32'(ok), 1);
    wait_drain(500);

    chk("leftover_tokens", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
